// File: rtl/date_counter.sv
`default_nettype none
// ============================================================================
// Module      : date_counter
// Description : Calendar stage of the digital clock. Keeps day, month and
//               year in BCD, advances one day per day_en strobe, handles
//               month lengths and leap years, and supports manual setting
//               of each field with day clamping.
// Revision    : 1.0 - initial release
// ============================================================================
module date_counter #(
    parameter logic [7:0] RST_DAY   = 8'h01,
    parameter logic [7:0] RST_MONTH = 8'h01,
    parameter logic [7:0] RST_YEAR  = 8'h24
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       day_en,
    input  logic       set_en,
    input  logic [1:0] set_sel,
    input  logic       set_inc,
    output logic [7:0] day_bcd,
    output logic [7:0] month_bcd,
    output logic [7:0] year_bcd,
    output logic       leap,
    output logic       month_wrap,
    output logic       year_wrap
);

    localparam logic [7:0] c_DAY_ONE   = 8'h01;
    localparam logic [7:0] c_MONTH_ONE = 8'h01;
    localparam logic [7:0] c_MONTH_DEC = 8'h12;
    localparam logic [7:0] c_YEAR_MAX  = 8'h99;
    localparam logic [7:0] c_YEAR_ZERO = 8'h00;

    localparam logic [1:0] c_SEL_DAY   = 2'b00;
    localparam logic [1:0] c_SEL_MONTH = 2'b01;
    localparam logic [1:0] c_SEL_YEAR  = 2'b10;

    // Two-digit BCD increment; callers handle the upper wrap themselves.
    function automatic logic [7:0] f_bcd_inc(input logic [7:0] v);
        logic [7:0] r;
        if (v[3:0] == 4'd9) begin
            r = {v[7:4] + 4'd1, 4'd0};
        end else begin
            r = {v[7:4], v[3:0] + 4'd1};
        end
        return r;
    endfunction

    // Year divisible by 4, evaluated directly on the BCD digits.
    function automatic logic f_is_leap(input logic [7:0] y);
        logic r;
        if (y[4] == 1'b0) begin
            r = (y[3:0] == 4'd0) || (y[3:0] == 4'd4) || (y[3:0] == 4'd8);
        end else begin
            r = (y[3:0] == 4'd2) || (y[3:0] == 4'd6);
        end
        return r;
    endfunction

    // Last day of the given month in BCD.
    function automatic logic [7:0] f_month_len(input logic [7:0] m, input logic lp);
        logic [7:0] r;
        case (m)
            8'h02:                      r = lp ? 8'h29 : 8'h28;
            8'h04, 8'h06, 8'h09, 8'h11: r = 8'h30;
            default:                    r = 8'h31;
        endcase
        return r;
    endfunction

    // Pull the day back onto the last legal day of a (possibly shorter) month.
    function automatic logic [7:0] f_clamp(input logic [7:0] d, input logic [7:0] max_d);
        return (d > max_d) ? max_d : d;
    endfunction

    logic [7:0] day_q,   day_d;
    logic [7:0] month_q, month_d;
    logic [7:0] year_q,  year_d;
    logic       month_wrap_q, month_wrap_d;
    logic       year_wrap_q,  year_wrap_d;

    logic       w_leap_cur;
    logic [7:0] w_day_max;
    logic [7:0] w_day_inc;
    logic [7:0] w_month_inc;
    logic [7:0] w_year_inc;
    logic       w_month_last;
    logic       w_year_last;

    assign w_leap_cur   = f_is_leap(year_q);
    assign w_day_max    = f_month_len(month_q, w_leap_cur);
    assign w_day_inc    = f_bcd_inc(day_q);
    assign w_month_last = (month_q == c_MONTH_DEC);
    assign w_year_last  = (year_q == c_YEAR_MAX);
    assign w_month_inc  = w_month_last ? c_MONTH_ONE : f_bcd_inc(month_q);
    assign w_year_inc   = w_year_last  ? c_YEAR_ZERO : f_bcd_inc(year_q);

    // Next-date selection: set mode fully overrides the daily advance.
    always_comb begin
        day_d        = day_q;
        month_d      = month_q;
        year_d       = year_q;
        month_wrap_d = 1'b0;
        year_wrap_d  = 1'b0;

        if (set_en) begin
            if (set_inc) begin
                case (set_sel)
                    c_SEL_DAY: begin
                        day_d = (day_q == w_day_max) ? c_DAY_ONE : w_day_inc;
                    end
                    c_SEL_MONTH: begin
                        month_d = w_month_inc;
                        day_d   = f_clamp(day_q, f_month_len(w_month_inc, w_leap_cur));
                    end
                    c_SEL_YEAR: begin
                        year_d = w_year_inc;
                        day_d  = f_clamp(day_q, f_month_len(month_q, f_is_leap(w_year_inc)));
                    end
                    default: begin
                        day_d = day_q;
                    end
                endcase
            end
        end else if (day_en) begin
            if (day_q == w_day_max) begin
                day_d   = c_DAY_ONE;
                month_d = w_month_inc;
                if (w_month_last) begin
                    month_wrap_d = 1'b1;
                    year_d       = w_year_inc;
                    year_wrap_d  = w_year_last;
                end
            end else begin
                day_d = w_day_inc;
            end
        end
    end

    // Date and wrap-pulse registers; reset aborts any pending advance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            day_q        <= RST_DAY;
            month_q      <= RST_MONTH;
            year_q       <= RST_YEAR;
            month_wrap_q <= 1'b0;
            year_wrap_q  <= 1'b0;
        end else begin
            day_q        <= day_d;
            month_q      <= month_d;
            year_q       <= year_d;
            month_wrap_q <= month_wrap_d;
            year_wrap_q  <= year_wrap_d;
        end
    end

    assign day_bcd    = day_q;
    assign month_bcd  = month_q;
    assign year_bcd   = year_q;
    assign leap       = w_leap_cur;
    assign month_wrap = month_wrap_q;
    assign year_wrap  = year_wrap_q;

endmodule
`default_nettype wire

// File: tb/tb_date_counter.sv
`default_nettype none
// ============================================================================
// Module      : tb_date_counter
// Description : Self-checking bench for date_counter: vector table, directed
//               corner sequences and randomized stimulus against an integer
//               calendar model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_date_counter;

    logic       clk;
    logic       rst_n;
    logic       day_en;
    logic       set_en;
    logic [1:0] set_sel;
    logic       set_inc;
    logic [7:0] day_bcd;
    logic [7:0] month_bcd;
    logic [7:0] year_bcd;
    logic       leap;
    logic       month_wrap;
    logic       year_wrap;

    date_counter dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .day_en     (day_en),
        .set_en     (set_en),
        .set_sel    (set_sel),
        .set_inc    (set_inc),
        .day_bcd    (day_bcd),
        .month_bcd  (month_bcd),
        .year_bcd   (year_bcd),
        .leap       (leap),
        .month_wrap (month_wrap),
        .year_wrap  (year_wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference calendar held as plain integers.
    int md, mm, my;
    bit mmw, myw;

    typedef struct {
        int       sd, sm, sy;
        bit       de, se;
        bit [1:0] sel;
        bit       inc;
        int       ed, em, ey;
        bit       ew_m, ew_y;
        string    name;
    } tvec_t;

    tvec_t vec [17];

    function automatic int mdays(input int m, input int y);
        if (m == 2)                                    return (y % 4 == 0) ? 29 : 28;
        if (m == 4 || m == 6 || m == 9 || m == 11)     return 30;
        return 31;
    endfunction

    function automatic logic [7:0] tobcd(input int v);
        return 8'(((v / 10) << 4) | (v % 10));
    endfunction

    task automatic check(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        md = 1; mm = 1; my = 24; mmw = 0; myw = 0;
    endtask

    task automatic model_update(input bit de, input bit se, input bit [1:0] sel, input bit inc);
        mmw = 0; myw = 0;
        if (se) begin
            if (inc) begin
                if (sel == 2'd0) begin
                    md = (md == mdays(mm, my)) ? 1 : md + 1;
                end else if (sel == 2'd1) begin
                    mm = (mm == 12) ? 1 : mm + 1;
                    if (md > mdays(mm, my)) md = mdays(mm, my);
                end else if (sel == 2'd2) begin
                    my = (my + 1) % 100;
                    if (md > mdays(mm, my)) md = mdays(mm, my);
                end
            end
        end else if (de) begin
            md++;
            if (md > mdays(mm, my)) begin
                md = 1;
                mm++;
                if (mm > 12) begin
                    mm = 1; mmw = 1;
                    my++;
                    if (my > 99) begin
                        my = 0; myw = 1;
                    end
                end
            end
        end
    endtask

    task automatic compare_model(input string nm);
        check({nm, ".day"},   int'(day_bcd),    int'(tobcd(md)));
        check({nm, ".month"}, int'(month_bcd),  int'(tobcd(mm)));
        check({nm, ".year"},  int'(year_bcd),   int'(tobcd(my)));
        check({nm, ".leap"},  int'(leap),       (my % 4 == 0) ? 1 : 0);
        check({nm, ".mwrap"}, int'(month_wrap), int'(mmw));
        check({nm, ".ywrap"}, int'(year_wrap),  int'(myw));
    endtask

    task automatic check_date(input string nm, input int d, input int m, input int y);
        check({nm, ".day"},   int'(day_bcd),   int'(tobcd(d)));
        check({nm, ".month"}, int'(month_bcd), int'(tobcd(m)));
        check({nm, ".year"},  int'(year_bcd),  int'(tobcd(y)));
    endtask

    // One clock with the given controls; called and returns at posedge+1.
    task automatic step(input bit de, input bit se, input bit [1:0] sel, input bit inc,
                        input string nm);
        day_en  = de;
        set_en  = se;
        set_sel = sel;
        set_inc = inc;
        @(posedge clk);
        #1;
        model_update(de, se, sel, inc);
        compare_model(nm);
        day_en  = 1'b0;
        set_en  = 1'b0;
        set_sel = 2'b11;
        set_inc = 1'b0;
    endtask

    // Walk the date to a target through set mode, steered by the model.
    task automatic set_date(input int d, input int m, input int y);
        for (int i = 0; i < 100 && my != y; i++) step(0, 1, 2'd2, 1, "set_y");
        for (int i = 0; i < 12 && mm != m; i++)  step(0, 1, 2'd1, 1, "set_m");
        for (int i = 0; i < 31 && md != d; i++)  step(0, 1, 2'd0, 1, "set_d");
        check("set_date.day", md, d);
    endtask

    int leap_years [5] = '{0, 12, 96, 10, 98};
    int leap_exp   [5] = '{1, 1, 1, 0, 0};

    initial begin
        vec[0]  = '{30, 4, 24, 1, 0, 2'd3, 0,  1, 5, 24, 0, 0, "apr30"};
        vec[1]  = '{31, 5, 24, 1, 0, 2'd3, 0,  1, 6, 24, 0, 0, "may31"};
        vec[2]  = '{28, 2, 23, 1, 0, 2'd3, 0,  1, 3, 23, 0, 0, "feb28_noleap"};
        vec[3]  = '{28, 2, 24, 1, 0, 2'd3, 0, 29, 2, 24, 0, 0, "feb28_leap"};
        vec[4]  = '{29, 2, 24, 1, 0, 2'd3, 0,  1, 3, 24, 0, 0, "feb29"};
        vec[5]  = '{31, 12, 99, 1, 0, 2'd3, 0, 1, 1,  0, 1, 1, "dec31_99"};
        vec[6]  = '{31, 12, 23, 1, 0, 2'd3, 0, 1, 1, 24, 1, 0, "dec31_23"};
        vec[7]  = '{ 9, 3, 24, 1, 0, 2'd3, 0, 10, 3, 24, 0, 0, "carry09"};
        vec[8]  = '{29, 3, 24, 1, 0, 2'd3, 0, 30, 3, 24, 0, 0, "carry29"};
        vec[9]  = '{31, 1, 23, 0, 1, 2'd1, 1, 28, 2, 23, 0, 0, "set_m_clamp"};
        vec[10] = '{29, 2, 24, 0, 1, 2'd2, 1, 28, 2, 25, 0, 0, "set_y_clamp"};
        vec[11] = '{30, 4, 24, 0, 1, 2'd0, 1,  1, 4, 24, 0, 0, "set_d_wrap"};
        vec[12] = '{15, 12, 24, 1, 1, 2'd1, 1, 15, 1, 24, 0, 0, "set_beats_day_en"};
        vec[13] = '{31, 12, 99, 0, 1, 2'd2, 1, 31, 12, 0, 0, 0, "set_y_wrap"};
        vec[14] = '{15, 6, 24, 1, 1, 2'd3, 1, 15, 6, 24, 0, 0, "sel11_day_en"};
        vec[15] = '{15, 6, 24, 0, 0, 2'd1, 1, 15, 6, 24, 0, 0, "inc_no_set"};
        vec[16] = '{31, 3, 24, 0, 1, 2'd1, 1, 30, 4, 24, 0, 0, "set_m_clamp30"};

        rst_n   = 1'b0;
        day_en  = 1'b0;
        set_en  = 1'b0;
        set_sel = 2'b11;
        set_inc = 1'b0;
        model_reset();
        #12;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        compare_model("reset");

        // Vector table
        foreach (vec[k]) begin
            set_date(vec[k].sd, vec[k].sm, vec[k].sy);
            step(vec[k].de, vec[k].se, vec[k].sel, vec[k].inc, vec[k].name);
            check_date({vec[k].name, ".vec"}, vec[k].ed, vec[k].em, vec[k].ey);
            check({vec[k].name, ".vec.mwrap"}, int'(month_wrap), int'(vec[k].ew_m));
            check({vec[k].name, ".vec.ywrap"}, int'(year_wrap),  int'(vec[k].ew_y));
        end

        // Year rollover with day_en held: wraps last exactly one cycle
        set_date(31, 12, 99);
        step(1, 0, 2'd3, 0, "hold1");
        check("hold1.mwrap", int'(month_wrap), 1);
        check("hold1.ywrap", int'(year_wrap), 1);
        step(1, 0, 2'd3, 0, "hold2");
        check_date("hold2", 2, 1, 0);
        check("hold2.mwrap", int'(month_wrap), 0);
        check("hold2.ywrap", int'(year_wrap), 0);
        step(1, 0, 2'd3, 0, "hold3");
        check_date("hold3", 3, 1, 0);

        // Set and clamp sequence
        set_date(31, 1, 23);
        step(0, 1, 2'd1, 1, "seq_m");
        check_date("seq_m", 28, 2, 23);
        step(0, 1, 2'd2, 1, "seq_y");
        check_date("seq_y", 28, 2, 24);
        step(0, 1, 2'd0, 1, "seq_d1");
        check_date("seq_d1", 29, 2, 24);
        step(0, 1, 2'd0, 1, "seq_d2");
        check_date("seq_d2", 1, 2, 24);

        // Leap flag on selected years
        foreach (leap_years[k]) begin
            set_date(1, 1, leap_years[k]);
            check("leap_flag", int'(leap), leap_exp[k]);
        end

        // Asynchronous reset in mid-cycle with an advance pending
        set_date(15, 7, 30);
        day_en = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        check_date("async_rst", 1, 1, 24);
        check("async_rst.mwrap", int'(month_wrap), 0);
        check("async_rst.ywrap", int'(year_wrap), 0);
        @(posedge clk);
        #1;
        check_date("rst_held", 1, 1, 24);
        day_en = 1'b0;
        rst_n  = 1'b1;
        model_reset();
        step(0, 0, 2'd3, 0, "post_rst");

        // Randomized stimulus against the model
        for (int i = 0; i < 3000; i++) begin
            bit       de, se, inc;
            bit [1:0] sel;
            de  = ($urandom_range(0, 9) < 8);
            se  = ($urandom_range(0, 9) < 2);
            sel = 2'($urandom_range(0, 3));
            inc = 1'($urandom_range(0, 1));
            step(de, se, sel, inc, "rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
